// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg: shared types and helpers for the JK bank arbiter.
//   arb_state_e : arbiter state (IDLE / LOCKED)
//   JK_*        : JK command encodings, {j,k}
//   jk_next     : next value of one JK bit
package jk_bank_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   function automatic logic jk_next(input logic q, input logic j, input logic k);
      logic r;
      case ({j, k})
         JK_HOLD: r = q;
         JK_CLR:  r = 1'b0;
         JK_SET:  r = 1'b1;
         default: r = ~q;   // JK_TGL
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jk_bank.sv
// jk_bank: NBITS JK-style state bits sharing one enable.
//   clk, rst : clock, async active-high reset (bits clear to 0)
//   en       : apply j/k this edge; otherwise hold
//   j, k     : per-bit JK command
//   q        : bank state
module jk_bank
   import jk_bank_pkg::*;
#(
   parameter int NBITS = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [NBITS-1:0] j,
   input  logic [NBITS-1:0] k,
   output logic [NBITS-1:0] q
);

   logic [NBITS-1:0] q_nxt;

   always_comb begin
      q_nxt = q;
      for (int b = 0; b < NBITS; b++) q_nxt[b] = jk_next(q[b], j[b], k[b]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= '0;
      else if (en) q <= q_nxt;
   end

endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter sharing one JK bank among NREQ
// requesters, with optional multi-cycle bank locking by the winner.
//   clk, rst     : clock, async active-high reset
//   req_valid    : per-requester command pending
//   req_lock     : per-requester "keep the bank after this grant"
//   req_j, req_k : per-requester JK masks, slice r at [r*NBITS +: NBITS]
//   gnt          : one-hot (or zero) acceptance this cycle
//   q            : bank state
//   locked       : bank held by owner
//   owner        : lock holder index (0 while unlocked)
module jk_bank_arbiter
   import jk_bank_pkg::*;
#(
   parameter  int NREQ  = 4,
   parameter  int NBITS = 8,
   localparam int OW    = (NREQ > 1) ? $clog2(NREQ) : 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_lock,
   input  logic [NREQ*NBITS-1:0] req_j,
   input  logic [NREQ*NBITS-1:0] req_k,
   output logic [NREQ-1:0]       gnt,
   output logic [NBITS-1:0]      q,
   output logic                  locked,
   output logic [OW-1:0]         owner
);

   arb_state_e       state;
   logic [OW-1:0]    ptr, owner_r, win, sel;
   logic             win_found, accept, sel_lock;
   logic [NBITS-1:0] sel_j, sel_k;

   function automatic logic [OW-1:0] ptr_inc(input logic [OW-1:0] x);
      return (int'(x) == NREQ - 1) ? '0 : x + OW'(1);
   endfunction

   // First valid requester at or after ptr, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      win       = '0;
      win_found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win       = OW'(idx);
         end
      end
   end

   // Grant depends only on state, ptr and valids; held low during reset.
   always_comb begin
      gnt = '0;
      if (!rst) begin
         if (state == LOCKED) gnt[owner_r] = req_valid[owner_r];
         else if (win_found)  gnt[win]     = 1'b1;
      end
   end

   assign sel      = (state == LOCKED) ? owner_r : win;
   assign accept   = |(gnt & req_valid);
   assign sel_lock = req_lock[sel];
   assign sel_j    = req_j[int'(sel)*NBITS +: NBITS];
   assign sel_k    = req_k[int'(sel)*NBITS +: NBITS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         owner_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (sel_lock) begin
                     owner_r <= win;
                     state   <= LOCKED;
                  end else begin
                     ptr <= ptr_inc(win);
                  end
               end
            end
            LOCKED: begin
               // Owner lock low releases either way: with valid it is a final
               // accepted command, without valid it is a bare release.
               if (!req_lock[owner_r]) begin
                  state   <= IDLE;
                  ptr     <= ptr_inc(owner_r);
                  owner_r <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign locked = (state == LOCKED);
   assign owner  = owner_r;

   jk_bank #(.NBITS(NBITS)) u_bank (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .j   (sel_j),
      .k   (sel_k),
      .q   (q)
   );

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench: stimulus pushes {expected gnt, expected q after accept};
// the monitor pops on every observed accept and checks q one cycle later.
module tb_jk_bank_arbiter;

   localparam int NREQ  = 4;
   localparam int NBITS = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid, req_lock, gnt;
   logic [NREQ*NBITS-1:0] req_j, req_k;
   logic [NBITS-1:0]      q;
   logic                  locked;
   logic [1:0]            owner;

   typedef struct {
      logic [NREQ-1:0]  g;
      logic [NBITS-1:0] q;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_lock  (req_lock),
      .req_j     (req_j),
      .req_k     (req_k),
      .gnt       (gnt),
      .q         (q),
      .locked    (locked),
      .owner     (owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic setr(input int r, input logic v, input logic l,
                       input logic [7:0] j, input logic [7:0] k);
      req_valid[r]          = v;
      req_lock[r]           = l;
      req_j[r*NBITS +: NBITS] = j;
      req_k[r*NBITS +: NBITS] = k;
   endtask

   task automatic push(input logic [3:0] g, input logic [7:0] qq);
      exp_t e;
      e.g = g;
      e.q = qq;
      sb.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Monitor: mid-cycle, check pending q, then any new accept.
   initial begin
      exp_t       e;
      logic       q_pend;
      logic [7:0] q_exp;
      q_pend = 1'b0;
      q_exp  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            q_pend = 1'b0;
         end else begin
            if (q_pend) begin
               chk("q_after_accept", {24'b0, q}, {24'b0, q_exp});
               q_pend = 1'b0;
            end
            if (|(gnt & req_valid)) begin
               if (sb.size() == 0) begin
                  chk("unexpected_accept", {28'b0, gnt}, 32'b0);
               end else begin
                  e = sb.pop_front();
                  chk("gnt", {28'b0, gnt}, {28'b0, e.g});
                  q_pend = 1'b1;
                  q_exp  = e.q;
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; req_valid = '0; req_lock = '0; req_j = '0; req_k = '0;
      #3 req_valid = '1;
      #1 chk("rst_gnt", {28'b0, gnt}, 32'h0);
      req_valid = '0;
      chk("rst_q", {24'b0, q}, 32'h0);
      chk("rst_locked", {31'b0, locked}, 32'h0);
      chk("rst_owner", {30'b0, owner}, 32'h0);
      @(posedge clk); cyc();
      rst = 1'b0;

      // single command from r1
      setr(1, 1, 0, 8'hF0, 8'h00); push(4'b0010, 8'hF0); cyc();
      setr(1, 0, 0, 8'h00, 8'h00);

      // toggle (ptr=2 picks r2 over r0), then clear from r3
      setr(0, 1, 0, 8'h01, 8'h00); setr(2, 1, 0, 8'hFF, 8'hFF);
      push(4'b0100, 8'h0F); cyc();
      setr(2, 0, 0, 8'h00, 8'h00); setr(3, 1, 0, 8'h00, 8'h0F);
      push(4'b1000, 8'h00); cyc();

      // full contention from ptr=0
      setr(1, 1, 0, 8'h02, 8'h00); setr(2, 1, 0, 8'h04, 8'h00); setr(3, 1, 0, 8'h08, 8'h00);
      push(4'b0001, 8'h01); push(4'b0010, 8'h03); push(4'b0100, 8'h07);
      push(4'b1000, 8'h0F); push(4'b0001, 8'h0F);
      repeat (5) cyc();
      req_valid = '0;

      // lock burst by r2 (ptr=1) with r0/r3 waiting
      setr(0, 1, 0, 8'h00, 8'hFF); setr(2, 1, 1, 8'hAA, 8'h00); setr(3, 1, 0, 8'h0A, 8'h00);
      push(4'b0100, 8'hAF); cyc();
      chk("burst_locked", {31'b0, locked}, 32'h1);
      chk("burst_owner", {30'b0, owner}, 32'h2);
      setr(2, 1, 1, 8'h00, 8'h0F); push(4'b0100, 8'hA0); cyc();
      setr(2, 1, 0, 8'h55, 8'h55); push(4'b0100, 8'hF5); cyc();
      chk("burst_unlocked", {31'b0, locked}, 32'h0);
      setr(2, 0, 0, 8'h00, 8'h00); push(4'b1000, 8'hFF); cyc();
      setr(3, 0, 0, 8'h00, 8'h00); push(4'b0001, 8'h00); cyc();
      setr(0, 0, 0, 8'h00, 8'h00);

      // lock stall by r1, then release without command
      setr(1, 1, 1, 8'h3C, 8'h00); push(4'b0010, 8'h3C); cyc();
      setr(1, 0, 1, 8'h00, 8'h00); setr(2, 1, 0, 8'hC3, 8'h00);
      repeat (5) begin
         #1;
         chk("stall_gnt", {28'b0, gnt}, 32'h0);
         chk("stall_locked", {31'b0, locked}, 32'h1);
         cyc();
      end
      setr(1, 0, 0, 8'h00, 8'h00);
      #1 chk("release_gnt", {28'b0, gnt}, 32'h0);
      push(4'b0100, 8'hFF); cyc();
      chk("release_locked", {31'b0, locked}, 32'h0);
      chk("release_owner", {30'b0, owner}, 32'h0);
      cyc();
      setr(2, 0, 0, 8'h00, 8'h00);

      // reset mid-burst: r3 (ptr=3) locks with q=AA
      setr(3, 1, 1, 8'hAA, 8'h55); push(4'b1000, 8'hAA); cyc();
      setr(3, 0, 1, 8'h00, 8'h00); cyc();
      setr(3, 1, 1, 8'hFF, 8'h00); setr(0, 1, 0, 8'h81, 8'h00);
      #1 chk("pre_rst_q", {24'b0, q}, 32'hAA);
      chk("pre_rst_locked", {31'b0, locked}, 32'h1);
      rst = 1'b1;
      #1 chk("midrst_q", {24'b0, q}, 32'h0);
      chk("midrst_locked", {31'b0, locked}, 32'h0);
      chk("midrst_gnt", {28'b0, gnt}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      setr(3, 1, 0, 8'hFF, 8'h00); push(4'b0001, 8'h81); cyc();
      setr(0, 0, 0, 8'h00, 8'h00); push(4'b1000, 8'hFF); cyc();
      setr(3, 0, 0, 8'h00, 8'h00);
      repeat (3) cyc();
      chk("sb_drained", sb.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
